// File: rtl/pcie_pkg.sv
// Shared types and credit helpers for the TL transmit credit gate.
package pcie_pkg;

    localparam int HDR_W_DEF = 8;
    localparam int DAT_W_DEF = 12;

    typedef enum logic [2:0] {
        FC_PH   = 3'd0,
        FC_PD   = 3'd1,
        FC_NPH  = 3'd2,
        FC_NPD  = 3'd3,
        FC_CPLH = 3'd4,
        FC_CPLD = 3'd5
    } fc_type_t;

    typedef enum logic [1:0] {
        TLP_P       = 2'd0,
        TLP_NP      = 2'd1,
        TLP_CPL     = 2'd2,
        TLP_ILLEGAL = 2'd3
    } tlp_class_t;

    typedef enum logic [1:0] {
        GATE_INIT  = 2'd0,
        GATE_RUN   = 2'd1,
        GATE_BLOCK = 2'd2
    } gate_state_t;

    // One data credit covers 4 DW; a zero-length TLP needs none.
    function automatic logic [11:0] fc_credits_needed(input logic [10:0] len_dw);
        logic [11:0] sum;
        sum = {1'b0, len_dw} + 12'd3;
        return {2'b00, sum[11:2]};
    endfunction

endpackage

// File: rtl/pcie_fc_credit_counter.sv
// One flow-control credit type: limit/consumed/infinite with modular check and update validation.
// Check is combinational from state; updates and consumption apply at the next edge, no backpressure.
module pcie_fc_credit_counter #(
    parameter int W = 8
) (
    input  logic         clk_sys,
    input  logic         rst_n_sys,
    input  logic         init_vld,
    input  logic         upd_vld,
    input  logic [W-1:0] value,
    input  logic [W-1:0] need,
    input  logic         consume,
    output logic         ok,
    output logic         upd_err
);

    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] cl_q, cl_d;
    logic [W-1:0] cc_q, cc_d;
    logic         inf_q, inf_d;
    logic [W-1:0] room;
    logic [W-1:0] upd_gap;
    logic         upd_fits;

    always_comb begin
        room     = cl_q - cc_q - need;
        upd_gap  = value - cc_q;
        upd_fits = (upd_gap <= HALF);
        ok       = inf_q | (room <= HALF);
        upd_err  = upd_vld & ~inf_q & ~upd_fits;

        cl_d  = cl_q;
        cc_d  = cc_q;
        inf_d = inf_q;
        if (init_vld) begin
            cl_d  = value;
            inf_d = (value == '0);
        end else if (upd_vld && !inf_q && upd_fits) begin
            cl_d = value;
        end
        // Consumption is independent of a same-cycle limit update; both land.
        if (consume) begin
            cc_d = cc_q + need;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            cl_q  <= '0;
            cc_q  <= '0;
            inf_q <= 1'b0;
        end else begin
            cl_q  <= cl_d;
            cc_q  <= cc_d;
            inf_q <= inf_d;
        end
    end

endmodule

// File: rtl/pcie_tl_tx_credit_gate.sv
// Gates single-beat TLPs against link-partner FC credits and forwards them through one output register.
// Latency 1 cycle; req_ready drops when credits are short or the output register is held by tl_tx_ready.
module pcie_tl_tx_credit_gate
    import pcie_pkg::*;
#(
    parameter int HDR_W         = HDR_W_DEF,
    parameter int DAT_W         = DAT_W_DEF,
    parameter int STALL_TIMEOUT = 4096
) (
    input  logic         clk_sys,
    input  logic         rst_n_sys,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_hdr,
    input  logic [255:0] req_data,
    input  logic         req_end,
    input  logic [1:0]   req_class,
    input  logic [10:0]  req_len_dw,
    input  logic         fc_upd_valid,
    input  logic         fc_upd_init,
    input  logic [2:0]   fc_upd_type,
    input  logic [11:0]  fc_upd_value,
    output logic         tl_tx_valid,
    input  logic         tl_tx_ready,
    output logic [31:0]  tl_tx_hdr,
    output logic [255:0] tl_tx_data,
    output logic         tl_tx_end,
    output logic         fc_init_done,
    output logic         credit_stall,
    output logic [1:0]   stall_class,
    output logic         fc_proto_err
);

    localparam int               CNT_W     = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_TIMEOUT);

    logic [5:0]       seen_q;
    logic [5:0]       init_vld;
    logic [5:0]       upd_vld;
    logic [5:0]       upd_err;
    logic [2:0]       hdr_ok;
    logic [2:0]       dat_ok;
    logic [2:0]       cls_sel;
    logic [DAT_W-1:0] dat_need;
    logic             credit_ok;
    logic             out_free;
    logic             handshake;
    logic             accept;
    logic             drop;
    logic             early_upd;
    logic             err_d, err_q;

    gate_state_t      state_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [1:0]       stall_class_q;

    logic             tx_vld_q;
    logic [31:0]      tx_hdr_q;
    logic [255:0]     tx_data_q;
    logic             tx_end_q;

    assign fc_init_done = &seen_q;
    assign dat_need     = DAT_W'(fc_credits_needed(req_len_dw));

    always_comb begin
        for (int t = 0; t < 6; t++) begin
            init_vld[t] = fc_upd_valid & fc_upd_init & ~fc_init_done & (fc_upd_type == 3'(t));
            upd_vld[t]  = fc_upd_valid & ~fc_upd_init & fc_init_done & (fc_upd_type == 3'(t));
        end
        early_upd = fc_upd_valid & ~fc_upd_init & ~fc_init_done;
    end

    // Types are ordered header/data per class, so class c owns counters 2c and 2c+1.
    for (genvar c = 0; c < 3; c++) begin : g_cls
        pcie_fc_credit_counter #(.W(HDR_W)) u_hdr (
            .clk_sys   (clk_sys),
            .rst_n_sys (rst_n_sys),
            .init_vld  (init_vld[2*c]),
            .upd_vld   (upd_vld[2*c]),
            .value     (fc_upd_value[HDR_W-1:0]),
            .need      (HDR_W'(1)),
            .consume   (accept & cls_sel[c]),
            .ok        (hdr_ok[c]),
            .upd_err   (upd_err[2*c])
        );
        pcie_fc_credit_counter #(.W(DAT_W)) u_dat (
            .clk_sys   (clk_sys),
            .rst_n_sys (rst_n_sys),
            .init_vld  (init_vld[2*c+1]),
            .upd_vld   (upd_vld[2*c+1]),
            .value     (fc_upd_value[DAT_W-1:0]),
            .need      (dat_need),
            .consume   (accept & cls_sel[c]),
            .ok        (dat_ok[c]),
            .upd_err   (upd_err[2*c+1])
        );
    end

    always_comb begin
        cls_sel   = 3'b000;
        credit_ok = 1'b1;
        case (req_class)
            TLP_P:   begin cls_sel = 3'b001; credit_ok = hdr_ok[0] & dat_ok[0]; end
            TLP_NP:  begin cls_sel = 3'b010; credit_ok = hdr_ok[1] & dat_ok[1]; end
            TLP_CPL: begin cls_sel = 3'b100; credit_ok = hdr_ok[2] & dat_ok[2]; end
            default: begin cls_sel = 3'b000; credit_ok = 1'b1; end
        endcase
        out_free  = ~tx_vld_q | tl_tx_ready;
        req_ready = fc_init_done & out_free & credit_ok;
        handshake = req_valid & req_ready;
        accept    = handshake & (req_class != TLP_ILLEGAL);
        drop      = handshake & (req_class == TLP_ILLEGAL);
        err_d     = err_q | early_upd | (|upd_err) | drop;
    end

    always_ff @(posedge clk_sys or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            seen_q <= '0;
            err_q  <= 1'b0;
        end else begin
            seen_q <= seen_q | init_vld;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            state_q       <= GATE_INIT;
            stall_cnt_q   <= '0;
            stall_class_q <= 2'd0;
        end else begin
            case (state_q)
                GATE_INIT: begin
                    if (fc_init_done) state_q <= GATE_RUN;
                end
                GATE_RUN: begin
                    if (req_valid && !credit_ok) begin
                        state_q       <= GATE_BLOCK;
                        stall_class_q <= req_class;
                    end
                end
                GATE_BLOCK: begin
                    if (!req_valid || accept) begin
                        state_q       <= GATE_RUN;
                        stall_cnt_q   <= '0;
                        stall_class_q <= 2'd0;
                    end else if (stall_cnt_q != STALL_MAX) begin
                        stall_cnt_q <= stall_cnt_q + 1'b1;
                    end
                end
                default: state_q <= GATE_INIT;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            tx_vld_q  <= 1'b0;
            tx_hdr_q  <= '0;
            tx_data_q <= '0;
            tx_end_q  <= 1'b0;
        end else if (accept) begin
            tx_vld_q  <= 1'b1;
            tx_hdr_q  <= req_hdr;
            tx_data_q <= req_data;
            tx_end_q  <= req_end;
        end else if (tl_tx_ready) begin
            tx_vld_q <= 1'b0;
        end
    end

    assign tl_tx_valid  = tx_vld_q;
    assign tl_tx_hdr    = tx_hdr_q;
    assign tl_tx_data   = tx_data_q;
    assign tl_tx_end    = tx_end_q;
    assign credit_stall = (stall_cnt_q == STALL_MAX);
    assign stall_class  = stall_class_q;
    assign fc_proto_err = err_q;

endmodule

// File: tb/tb_pcie_tl_tx_credit_gate.sv
// Directed bench for the TL transmit credit gate with a scoreboard on the tl_tx side.
module tb_pcie_tl_tx_credit_gate;
    import pcie_pkg::*;

    localparam int TO = 16;

    logic         clk_sys = 1'b0;
    logic         rst_n_sys;
    logic         req_valid, req_ready;
    logic [31:0]  req_hdr;
    logic [255:0] req_data;
    logic         req_end;
    logic [1:0]   req_class;
    logic [10:0]  req_len_dw;
    logic         fc_upd_valid, fc_upd_init;
    logic [2:0]   fc_upd_type;
    logic [11:0]  fc_upd_value;
    logic         tl_tx_valid, tl_tx_ready;
    logic [31:0]  tl_tx_hdr;
    logic [255:0] tl_tx_data;
    logic         tl_tx_end;
    logic         fc_init_done, credit_stall, fc_proto_err;
    logic [1:0]   stall_class;

    always #5 clk_sys = ~clk_sys;

    pcie_tl_tx_credit_gate #(.HDR_W(8), .DAT_W(12), .STALL_TIMEOUT(TO)) dut (
        .clk_sys      (clk_sys),
        .rst_n_sys    (rst_n_sys),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_hdr      (req_hdr),
        .req_data     (req_data),
        .req_end      (req_end),
        .req_class    (req_class),
        .req_len_dw   (req_len_dw),
        .fc_upd_valid (fc_upd_valid),
        .fc_upd_init  (fc_upd_init),
        .fc_upd_type  (fc_upd_type),
        .fc_upd_value (fc_upd_value),
        .tl_tx_valid  (tl_tx_valid),
        .tl_tx_ready  (tl_tx_ready),
        .tl_tx_hdr    (tl_tx_hdr),
        .tl_tx_data   (tl_tx_data),
        .tl_tx_end    (tl_tx_end),
        .fc_init_done (fc_init_done),
        .credit_stall (credit_stall),
        .stall_class  (stall_class),
        .fc_proto_err (fc_proto_err)
    );

    typedef struct packed {
        logic [31:0]  hdr;
        logic [255:0] data;
        logic         e;
    } tlp_t;

    tlp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Output side: every completed tl_tx handshake must match the oldest expected TLP.
    always @(negedge clk_sys) begin
        if (rst_n_sys && tl_tx_valid && tl_tx_ready) begin
            chk("tx_expected_pending", 300'(exp_q.size() != 0), 300'(1));
            if (exp_q.size() != 0) begin
                tlp_t t;
                t = exp_q.pop_front();
                chk("tx_hdr", 300'(tl_tx_hdr), 300'(t.hdr));
                chk("tx_data", 300'(tl_tx_data), 300'(t.data));
                chk("tx_end", 300'(tl_tx_end), 300'(t.e));
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic fc(input logic init, input logic [2:0] typ, input logic [11:0] val);
        fc_upd_valid = 1'b1;
        fc_upd_init  = init;
        fc_upd_type  = typ;
        fc_upd_value = val;
        step();
        fc_upd_valid = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] cls, input logic [10:0] len,
                             input logic [31:0] hdr, input logic vld);
        req_valid  = vld;
        req_class  = cls;
        req_len_dw = len;
        req_hdr    = hdr;
        req_data   = {8{hdr}};
        req_end    = hdr[0];
    endtask

    task automatic push_cur();
        tlp_t t;
        t.hdr  = req_hdr;
        t.data = req_data;
        t.e    = req_end;
        exp_q.push_back(t);
    endtask

    task automatic send(input string tag, input logic [1:0] cls, input logic [10:0] len,
                        input logic [31:0] hdr, input logic exp_rdy);
        drive_req(cls, len, hdr, 1'b1);
        #1;
        chk(tag, 300'(req_ready), 300'(exp_rdy));
        if (exp_rdy && cls != 2'd3) push_cur();
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_sys = 1'b0;
        exp_q.delete();
        step();
        step();
        rst_n_sys = 1'b1;
        step();
    endtask

    initial begin
        rst_n_sys    = 1'b1;
        tl_tx_ready  = 1'b1;
        fc_upd_valid = 1'b0;
        fc_upd_init  = 1'b0;
        fc_upd_type  = 3'd0;
        fc_upd_value = 12'd0;
        drive_req(2'd0, 11'd16, 32'h0, 1'b0);
        #1 rst_n_sys = 1'b0;
        repeat (3) step();

        chk("rst_req_ready", 300'(req_ready), 300'(0));
        chk("rst_tx_valid", 300'(tl_tx_valid), 300'(0));
        chk("rst_tx_end", 300'(tl_tx_end), 300'(0));
        chk("rst_init_done", 300'(fc_init_done), 300'(0));
        chk("rst_stall", 300'(credit_stall), 300'(0));
        chk("rst_err", 300'(fc_proto_err), 300'(0));
        chk("rst_stall_class", 300'(stall_class), 300'(0));
        chk("rst_tx_hdr", 300'(tl_tx_hdr), 300'(0));
        chk("rst_tx_data", 300'(tl_tx_data), 300'(0));
        rst_n_sys = 1'b1;
        step();

        // UpdateFC before init is a protocol error; reset clears it.
        fc(1'b0, FC_PH, 12'd5);
        chk("err_upd_before_init", 300'(fc_proto_err), 300'(1));
        do_reset();
        chk("err_cleared_by_reset", 300'(fc_proto_err), 300'(0));

        drive_req(TLP_P, 11'd16, 32'h0, 1'b0);
        fc(1'b1, FC_PH, 12'd8);
        fc(1'b1, FC_PD, 12'd64);
        fc(1'b1, FC_NPH, 12'd4);
        fc(1'b1, FC_NPD, 12'd8);
        fc(1'b1, FC_CPLH, 12'd0);
        chk("init_done_early", 300'(fc_init_done), 300'(0));
        chk("ready_before_init", 300'(req_ready), 300'(0));
        fc(1'b1, FC_CPLD, 12'd0);
        chk("init_done", 300'(fc_init_done), 300'(1));
        chk("ready_after_init", 300'(req_ready), 300'(1));

        // Posted header exhaustion.
        for (int i = 0; i < 8; i++) send("ph_pass", TLP_P, 11'd16, 32'h1000 + i, 1'b1);
        drive_req(TLP_P, 11'd16, 32'h1100, 1'b1);
        #1 chk("ph_9th_blocked", 300'(req_ready), 300'(0));
        step();
        step();
        chk("ph_9th_still_blocked", 300'(req_ready), 300'(0));
        fc_upd_valid = 1'b1; fc_upd_init = 1'b0; fc_upd_type = FC_PH; fc_upd_value = 12'd9;
        #1 chk("ph_update_not_yet", 300'(req_ready), 300'(0));
        step();
        fc_upd_valid = 1'b0;
        #1 chk("ph_9th_released", 300'(req_ready), 300'(1));
        push_cur();
        step();
        req_valid = 1'b0;
        chk("ph_9th_out_valid", 300'(tl_tx_valid), 300'(1));
        chk("ph_9th_out_hdr", 300'(tl_tx_hdr), 300'(32'h1100));

        // Walk PD consumed up to 4090 with limit 4095; PH raised by exactly half the space.
        fc(1'b0, FC_PH, 12'd137);
        fc(1'b0, FC_PD, 12'd2000);
        for (int i = 0; i < 7; i++) send("pd_walk_a", TLP_P, 11'd1024, 32'h2000 + i, 1'b1);
        fc(1'b0, FC_PD, 12'd3800);
        for (int i = 0; i < 7; i++) send("pd_walk_b", TLP_P, 11'd1024, 32'h2100 + i, 1'b1);
        fc(1'b0, FC_PD, 12'd4095);
        send("pd_walk_c", TLP_P, 11'd1024, 32'h2200, 1'b1);
        send("pd_walk_d", TLP_P, 11'd856, 32'h2201, 1'b1);
        chk("no_err_valid_updates", 300'(fc_proto_err), 300'(0));
        fc(1'b0, FC_PD, 12'd8);
        send("wrap_32dw_pass", TLP_P, 11'd32, 32'h3000, 1'b1);
        drive_req(TLP_P, 11'd48, 32'h3001, 1'b1);
        #1 chk("wrap_48dw_block", 300'(req_ready), 300'(0));
        step();
        req_valid = 1'b0;
        step();

        for (int i = 0; i < 100; i++) send("cpl_infinite", TLP_CPL, 11'd1024, 32'h4000 + i, 1'b1);
        chk("cpl_no_stall", 300'(credit_stall), 300'(0));

        // Stall timeout with NPH exhausted.
        for (int i = 0; i < 4; i++) send("nph_pass", TLP_NP, 11'd1, 32'h5000 + i, 1'b1);
        drive_req(TLP_NP, 11'd1, 32'h5100, 1'b1);
        #1 chk("nph_blocked", 300'(req_ready), 300'(0));
        repeat (5) step();
        chk("stall_not_yet", 300'(credit_stall), 300'(0));
        repeat (15) step();
        chk("stall_set", 300'(credit_stall), 300'(1));
        chk("stall_class_np", 300'(stall_class), 300'(1));
        chk("stall_ready_low", 300'(req_ready), 300'(0));
        fc_upd_valid = 1'b1; fc_upd_init = 1'b0; fc_upd_type = FC_NPH; fc_upd_value = 12'd5;
        step();
        fc_upd_valid = 1'b0;
        #1 chk("nph_released", 300'(req_ready), 300'(1));
        push_cur();
        step();
        req_valid = 1'b0;
        chk("stall_cleared", 300'(credit_stall), 300'(0));
        chk("stall_class_cleared", 300'(stall_class), 300'(0));
        step();

        // Output backpressure: payload held, no new acceptance.
        tl_tx_ready = 1'b0;
        send("bp_first", TLP_CPL, 11'd4, 32'h6000, 1'b1);
        drive_req(TLP_CPL, 11'd4, 32'h6001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready_low", 300'(req_ready), 300'(0));
            chk("bp_valid_held", 300'(tl_tx_valid), 300'(1));
            chk("bp_hdr_held", 300'(tl_tx_hdr), 300'(32'h6000));
            step();
        end
        tl_tx_ready = 1'b1;
        #1 chk("bp_release_ready", 300'(req_ready), 300'(1));
        push_cur();
        step();
        req_valid = 1'b0;
        step();

        // Out-of-window UpdateFC leaves the limit alone.
        fc(1'b0, FC_NPH, 12'd205);
        chk("err_bad_update", 300'(fc_proto_err), 300'(1));
        drive_req(TLP_NP, 11'd1, 32'h0, 1'b0);
        #1 chk("nph_limit_unchanged", 300'(req_ready), 300'(0));

        // Reset with a TLP held in the output register.
        tl_tx_ready = 1'b0;
        send("pre_reset_tlp", TLP_P, 11'd4, 32'h7000, 1'b1);
        chk("pre_reset_valid", 300'(tl_tx_valid), 300'(1));
        do_reset();
        tl_tx_ready = 1'b1;
        chk("post_reset_valid", 300'(tl_tx_valid), 300'(0));
        chk("post_reset_init", 300'(fc_init_done), 300'(0));
        chk("post_reset_err", 300'(fc_proto_err), 300'(0));

        fc(1'b1, FC_PH, 12'd2);
        fc(1'b1, FC_PD, 12'd64);
        fc(1'b1, FC_NPH, 12'd2);
        fc(1'b1, FC_NPD, 12'd8);
        fc(1'b1, FC_CPLH, 12'd0);
        fc(1'b1, FC_CPLD, 12'd0);
        send("reinit_p0", TLP_P, 11'd4, 32'h7100, 1'b1);
        send("reinit_p1", TLP_P, 11'd4, 32'h7101, 1'b1);
        drive_req(TLP_P, 11'd4, 32'h7102, 1'b0);
        #1 chk("reinit_ph_exhausted", 300'(req_ready), 300'(0));
        step();

        // Illegal class: accepted and dropped.
        send("illegal_ready", TLP_ILLEGAL, 11'd4, 32'h8000, 1'b1);
        chk("illegal_err", 300'(fc_proto_err), 300'(1));
        step();
        chk("illegal_not_forwarded", 300'(tl_tx_valid), 300'(0));

        repeat (3) step();
        chk("scoreboard_drained", 300'(exp_q.size()), 300'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
